// File: rtl/signal_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// signal_phase_scheduler_if
//
// Bundle between the phase scheduler and its environment (timebase, request
// sensors, light-board enables and the countdown display driver).
// Member suffixes follow the scheduler's point of view: _i is driven into the
// scheduler, _o is driven by it.
//
//   tick_i         timebase strobe, one clk per timer tick
//   load_req_i     per-board density request (level)
//   emer_req_i     per-board emergency request (level)
//   grant_o        one-hot green enable per board
//   amber_o        one-hot amber enable per board
//   all_red_o      high while in the all-red clearance phase
//   cur_board_o    board currently or most recently served
//   phase_o        00 ALL_RED, 01 GREEN, 10 AMBER
//   countdown_o    ticks remaining in the current phase
//   emer_active_o  current green was granted by an emergency request
//
// Modports:
//   master  environment side (drives requests and tick, observes outputs)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface signal_phase_scheduler_if;

    logic       tick_i;
    logic [3:0] load_req_i;
    logic [3:0] emer_req_i;
    logic [3:0] grant_o;
    logic [3:0] amber_o;
    logic       all_red_o;
    logic [1:0] cur_board_o;
    logic [1:0] phase_o;
    logic [7:0] countdown_o;
    logic       emer_active_o;

    modport master (
        output tick_i,
        output load_req_i,
        output emer_req_i,
        input  grant_o,
        input  amber_o,
        input  all_red_o,
        input  cur_board_o,
        input  phase_o,
        input  countdown_o,
        input  emer_active_o
    );

    modport slave (
        input  tick_i,
        input  load_req_i,
        input  emer_req_i,
        output grant_o,
        output amber_o,
        output all_red_o,
        output cur_board_o,
        output phase_o,
        output countdown_o,
        output emer_active_o
    );

endinterface

// File: rtl/signal_phase_scheduler.sv
// -----------------------------------------------------------------------------
// signal_phase_scheduler
//
// Walks the four intersection light boards (B, L, F, R = 0..3) through timed
// GREEN -> AMBER -> ALL_RED phases. The served board is picked on the
// ALL_RED -> GREEN edge: emergency first (lowest index), then density
// requests scanned round-robin from the board after the current one, then
// plain round-robin. An emergency on the served board holds its green; an
// emergency on any other board cuts the green short into AMBER.
//
// State table:
//   phase   | meaning
//   --------+-------------------------------------------------------------
//   ALL_RED | clearance, all boards red; selection happens on its last tick
//   GREEN   | cur_board has green, may be held or preempted by emergencies
//   AMBER   | cur_board has amber, fixed length, never altered
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    signal_phase_scheduler_if.slave (tick, requests, enables, status)
//
// All outputs are decoded from registered state only, so they change on the
// same edge as the phase and carry no combinational path from the inputs.
// -----------------------------------------------------------------------------
module signal_phase_scheduler #(
    parameter int unsigned GREEN_TICKS  = 16,
    parameter int unsigned AMBER_TICKS  = 4,
    parameter int unsigned ALLRED_TICKS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    signal_phase_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_AMBER  = 2'b10
    } phase_e;

    localparam logic [7:0] GREEN_LOAD  = 8'(GREEN_TICKS);
    localparam logic [7:0] AMBER_LOAD  = 8'(AMBER_TICKS);
    localparam logic [7:0] ALLRED_LOAD = 8'(ALLRED_TICKS);

    phase_e     phase_q, phase_d;
    logic [1:0] board_q, board_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       emer_q,  emer_d;

    // next-board selection
    logic [1:0] sel_board;
    logic       sel_emer;
    logic [1:0] scan_idx;

    // timer and request qualifiers
    logic       cnt_last;
    logic [7:0] cnt_dec;
    logic [3:0] cur_onehot;
    logic       emer_cur;
    logic       emer_other;

    // decoded outputs
    logic [3:0] grant_c;
    logic [3:0] amber_c;
    logic       all_red_c;

    // -------------------------------------------------------------------------
    // Timer and request qualifiers
    // -------------------------------------------------------------------------
    assign cnt_last   = bus.tick_i && (cnt_q == 8'd1);
    assign cnt_dec    = cnt_q - 8'd1;
    assign cur_onehot = 4'b0001 << board_q;
    assign emer_cur   = |(bus.emer_req_i & cur_onehot);
    assign emer_other = |(bus.emer_req_i & ~cur_onehot);

    // -------------------------------------------------------------------------
    // Next-board selection. Only consumed on the ALL_RED -> GREEN edge.
    // Both loops run high-to-low so the last match (the winner) is the lowest
    // emergency index, or the nearest load request after board_q.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_board = board_q + 2'd1;
        sel_emer  = 1'b0;
        scan_idx  = board_q;
        if (|bus.emer_req_i) begin
            sel_emer = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                if (bus.emer_req_i[i]) begin
                    sel_board = 2'(i);
                end
            end
        end else if (|bus.load_req_i) begin
            // k = 4 wraps to board_q itself, so it is scanned last
            for (int k = 4; k >= 1; k--) begin
                scan_idx = board_q + 2'(k);
                if (bus.load_req_i[scan_idx]) begin
                    sel_board = scan_idx;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_ALLRED;
            board_q <= 2'd3;
            cnt_q   <= ALLRED_LOAD;
            emer_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            board_q <= board_d;
            cnt_q   <= cnt_d;
            emer_q  <= emer_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        board_d = board_q;
        cnt_d   = cnt_q;
        emer_d  = emer_q;

        unique case (phase_q)
            PH_ALLRED: begin
                if (cnt_last) begin
                    phase_d = PH_GREEN;
                    board_d = sel_board;
                    emer_d  = sel_emer;
                    cnt_d   = GREEN_LOAD;
                end else if (bus.tick_i) begin
                    cnt_d = cnt_dec;
                end
            end

            PH_GREEN: begin
                if (emer_cur) begin
                    // hold: the count is re-armed each tick so it never expires
                    if (bus.tick_i) begin
                        cnt_d = GREEN_LOAD;
                    end
                end else if (emer_other || cnt_last) begin
                    // preemption and expiry on the same edge collapse into one
                    phase_d = PH_AMBER;
                    cnt_d   = AMBER_LOAD;
                    emer_d  = 1'b0;
                end else if (bus.tick_i) begin
                    cnt_d = cnt_dec;
                end
            end

            PH_AMBER: begin
                if (cnt_last) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = ALLRED_LOAD;
                end else if (bus.tick_i) begin
                    cnt_d = cnt_dec;
                end
            end

            default: begin
                // unused encoding: recover into clearance
                phase_d = PH_ALLRED;
                cnt_d   = ALLRED_LOAD;
                emer_d  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode (registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        grant_c   = 4'b0000;
        amber_c   = 4'b0000;
        all_red_c = 1'b0;
        unique case (phase_q)
            PH_GREEN:  grant_c   = cur_onehot;
            PH_AMBER:  amber_c   = cur_onehot;
            default:   all_red_c = 1'b1;
        endcase
    end

    assign bus.grant_o       = grant_c;
    assign bus.amber_o       = amber_c;
    assign bus.all_red_o     = all_red_c;
    assign bus.cur_board_o   = board_q;
    assign bus.phase_o       = phase_q;
    assign bus.countdown_o   = cnt_q;
    assign bus.emer_active_o = emer_q;

endmodule
